// File: rtl/serial_tx_cfg.sv
// ---------------------------------------------------------------------------
// serial_tx_cfg -- configurable asynchronous-serial (UART-style) transmitter
//
// Sends one frame per accepted word: start bit (0), DATA_BITS data bits LSB
// first, an optional odd/even parity bit, then STOP_BITS stop bits (1). Each
// bit lasts DIV = CLK_FREQ / BIT_FREQ clocks. The bit timer is restarted at
// every accept, so the start edge is aligned to the accepting clock edge
// (no free-running baud tick, no start-bit jitter).
//
// Ports
//   sys_clk  in   system clock, rising edge
//   rst      in   asynchronous, active-high reset
//   wr       in   producer valid; word accepted when wr && ready
//   data     in   word to send (DATA_BITS wide), sampled on the accept cycle
//   ready    out  high when a new word can be accepted
//   done     out  one-cycle pulse in the last clock of the last stop bit
//   tx       out  serial line, idle/mark = 1 (registered, no input path)
// ---------------------------------------------------------------------------
module serial_tx_cfg #(
  parameter int CLK_FREQ  = 48000000,
  parameter int BIT_FREQ  = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,   // 0 none, 1 odd, 2 even, others = none
  parameter int STOP_BITS = 1
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 wr,
  input  logic [DATA_BITS-1:0] data,
  output logic                 ready,
  output logic                 done,
  output logic                 tx
);

  localparam int DIV   = CLK_FREQ / BIT_FREQ;
  localparam int DIV_W = (DIV >= 2) ? $clog2(DIV) : 1;
  localparam int BC_W  = $clog2(DATA_BITS + 1);

  localparam bit PAR_EN  = (PARITY == 1) || (PARITY == 2);
  localparam bit PAR_ODD = (PARITY == 1);

  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(DATA_BITS - 1);

  // Out-of-range configurations are rejected at elaboration.
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("serial_tx_cfg: DATA_BITS=%0d is outside 5..9", DATA_BITS);
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("serial_tx_cfg: STOP_BITS=%0d must be 1 or 2", STOP_BITS);
  end
  if (DIV < 2) begin : g_bad_div
    $error("serial_tx_cfg: CLK_FREQ/BIT_FREQ=%0d must be at least 2", DIV);
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [DIV_W-1:0]     div_q,   div_d;
  logic [BC_W-1:0]      bit_q,   bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q,   par_d;
  logic                 stop_q,  stop_d;   // index of the current stop bit
  logic                 tx_d, ready_d, done_d;

  logic accept;
  logic bit_end;
  logic stop_last;
  logic load_frame;

  assign accept    = wr && ready;
  assign bit_end   = (div_q == '0);
  assign stop_last = (STOP_BITS == 2) ? stop_q : 1'b1;

  // NOTE: every variable written here is given a default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    div_d      = bit_end ? DIV_LOAD : div_q - 1'b1;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    stop_d     = stop_q;
    tx_d       = tx;
    ready_d    = ready;
    done_d     = 1'b0;
    load_frame = 1'b0;

    case (state_q)
      ST_IDLE: begin
        div_d = '0;
        if (accept) load_frame = 1'b1;
      end

      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          bit_d   = '0;
          tx_d    = shreg_q[0];
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          bit_d   = bit_q + 1'b1;
          if (bit_q == LAST_BIT) begin
            if (PAR_EN) begin
              state_d = ST_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = ST_STOP;
              stop_d  = 1'b0;
              tx_d    = 1'b1;
            end
          end else begin
            tx_d = shreg_q[1];
          end
        end
      end

      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          stop_d  = 1'b0;
          tx_d    = 1'b1;
        end
      end

      ST_STOP: begin
        if (bit_end) begin
          if (stop_last) begin
            // ready was raised for this final cycle, so a waiting word starts
            // its start bit right after the last stop bit with no idle gap.
            if (accept) begin
              load_frame = 1'b1;
            end else begin
              state_d = ST_IDLE;
              div_d   = '0;
            end
          end else begin
            stop_d = 1'b1;
          end
        end else if (stop_last && div_q == DIV_ONE) begin
          // Registered, so done/ready show up in the last clock of the frame.
          done_d  = 1'b1;
          ready_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        div_d   = '0;
        tx_d    = 1'b1;
        ready_d = 1'b1;
      end
    endcase

    if (load_frame) begin
      shreg_d = data;
      par_d   = PAR_ODD ? ~^data : ^data;
      state_d = ST_START;
      div_d   = DIV_LOAD;
      bit_d   = '0;
      stop_d  = 1'b0;
      tx_d    = 1'b0;
      ready_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      stop_q  <= 1'b0;
      tx      <= 1'b1;
      ready   <= 1'b1;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      stop_q  <= stop_d;
      tx      <= tx_d;
      ready   <= ready_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_serial_tx_cfg.sv
// ---------------------------------------------------------------------------
// tb_serial_tx_cfg -- self-checking bench for serial_tx_cfg
//
// Four transmitters with DIV = 48/5 = 9 share clock and reset:
//   inst0 8N1, inst1 8E2, inst2 8O2, inst3 9 bits with PARITY=3 (= none), 1 stop.
// The reference model describes a frame as a list of line levels (start,
// data LSB first, parity from a ones count, stop bits), each lasting DIV
// clocks, with done and ready high only in the final clock of the frame.
// ---------------------------------------------------------------------------
module tb_serial_tx_cfg;

  localparam int DIV    = 9;
  localparam int N_INST = 4;
  localparam int CFG_DB  [N_INST] = '{8, 8, 8, 9};
  localparam int CFG_PAR [N_INST] = '{0, 2, 1, 3};
  localparam int CFG_SB  [N_INST] = '{1, 2, 2, 1};

  logic       sys_clk = 1'b0;
  logic       rst     = 1'b1;
  logic       wr    [N_INST];
  logic [8:0] data  [N_INST];
  logic       tx    [N_INST];
  logic       ready [N_INST];
  logic       done  [N_INST];

  int compared   = 0;
  int mismatched = 0;

  logic [8:0] frame_q[$];

  always #5 sys_clk = ~sys_clk;

  serial_tx_cfg #(.CLK_FREQ(48), .BIT_FREQ(5), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .sys_clk(sys_clk), .rst(rst), .wr(wr[0]), .data(data[0][7:0]),
    .ready(ready[0]), .done(done[0]), .tx(tx[0]));

  serial_tx_cfg #(.CLK_FREQ(48), .BIT_FREQ(5), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u_8e2 (
    .sys_clk(sys_clk), .rst(rst), .wr(wr[1]), .data(data[1][7:0]),
    .ready(ready[1]), .done(done[1]), .tx(tx[1]));

  serial_tx_cfg #(.CLK_FREQ(48), .BIT_FREQ(5), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) u_8o2 (
    .sys_clk(sys_clk), .rst(rst), .wr(wr[2]), .data(data[2][7:0]),
    .ready(ready[2]), .done(done[2]), .tx(tx[2]));

  serial_tx_cfg #(.CLK_FREQ(48), .BIT_FREQ(5), .DATA_BITS(9), .PARITY(3), .STOP_BITS(1)) u_9n1 (
    .sys_clk(sys_clk), .rst(rst), .wr(wr[3]), .data(data[3]),
    .ready(ready[3]), .done(done[3]), .tx(tx[3]));

  // ---------------------------------------------------------------- model
  function automatic bit par_on(input int i);
    return (CFG_PAR[i] == 1) || (CFG_PAR[i] == 2);
  endfunction

  function automatic int frame_bits(input int i);
    return 1 + CFG_DB[i] + (par_on(i) ? 1 : 0) + CFG_SB[i];
  endfunction

  // Line level of bit slot j of the frame carrying word d on instance i.
  function automatic logic model_line(input int i, input logic [8:0] d, input int j);
    int ones;
    ones = 0;
    if (j == 0) return 1'b0;
    if (j <= CFG_DB[i]) return d[j-1];
    if (par_on(i) && j == CFG_DB[i] + 1) begin
      for (int b = 0; b < CFG_DB[i]; b++) ones += int'(d[b]);
      // odd parity: total ones including parity bit is odd
      return (CFG_PAR[i] == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
    end
    return 1'b1;
  endfunction

  // ---------------------------------------------------------------- helpers
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Sends every word of frame_q on instance i back to back and checks each
  // clock of every frame. mode 0: wr held high, data held; mode 1: random
  // wr/data while busy; mode 2: wr=1 with all-ones data while busy.
  task automatic send_frames(input int i, input int mode, input string name);
    int         len;
    int         nf;
    logic [2:0] exp_v;
    logic [2:0] act_v;
    nf = frame_q.size();
    compared++;
    if (ready[i] !== 1'b1) begin
      mismatched++;
      $display("FAIL %s inst%0d ready before accept: got %b want 1", name, i, ready[i]);
    end
    wr[i]   = 1'b1;
    data[i] = frame_q[0];
    tick();
    for (int k = 0; k < nf; k++) begin
      len = frame_bits(i) * DIV;
      for (int c = 0; c < len; c++) begin
        exp_v = {model_line(i, frame_q[k], c / DIV), c == len - 1, c == len - 1};
        act_v = {tx[i], done[i], ready[i]};
        compared++;
        if (act_v !== exp_v) begin
          mismatched++;
          $display("FAIL %s inst%0d frame%0d cycle%0d {tx,done,ready}: got %b want %b",
                   name, i, k, c, act_v, exp_v);
        end
        if (c == len - 1) begin
          if (k + 1 < nf) begin
            wr[i]   = 1'b1;
            data[i] = frame_q[k+1];
          end else begin
            wr[i] = 1'b0;
          end
        end else if (mode == 1) begin
          wr[i]   = 1'($urandom_range(0, 1));
          data[i] = 9'($urandom);
        end else if (mode == 2) begin
          wr[i]   = 1'b1;
          data[i] = 9'h1FF;
        end
        tick();
      end
    end
    act_v = {tx[i], done[i], ready[i]};
    compared++;
    if (act_v !== 3'b101) begin
      mismatched++;
      $display("FAIL %s inst%0d idle after frames {tx,done,ready}: got %b want 101", name, i, act_v);
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    logic [2:0] act_v;
    rst = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < N_INST; i++) begin
      act_v = {tx[i], done[i], ready[i]};
      compared++;
      if (act_v !== 3'b101) begin
        mismatched++;
        $display("FAIL reset_hold inst%0d {tx,done,ready}: got %b want 101", i, act_v);
      end
    end
    rst = 1'b0;
    for (int c = 0; c < 200; c++) begin
      tick();
      for (int i = 0; i < N_INST; i++) begin
        act_v = {tx[i], done[i], ready[i]};
        compared++;
        if (act_v !== 3'b101) begin
          mismatched++;
          $display("FAIL idle inst%0d cycle%0d {tx,done,ready}: got %b want 101", i, c, act_v);
        end
      end
    end
  endtask

  task automatic test_single_frame();
    frame_q = '{9'h04B};
    send_frames(0, 0, "8n1_4B");
  endtask

  task automatic test_parity_stop2();
    frame_q = '{9'h04B};
    send_frames(1, 0, "8e2_4B");
    send_frames(2, 0, "8o2_4B");
    frame_q = '{9'h001};
    send_frames(1, 0, "8e2_01");
    send_frames(2, 0, "8o2_01");
  endtask

  task automatic test_back_to_back();
    frame_q = '{9'h055, 9'h0AA};
    send_frames(0, 0, "b2b_8n1");
    frame_q = '{9'h0F0, 9'h00F, 9'h081};
    send_frames(1, 0, "b2b_8e2");
  endtask

  task automatic test_ignored_write();
    frame_q = '{9'h000};
    send_frames(0, 2, "ignore_wr");
  endtask

  task automatic test_reset_mid_frame();
    logic [2:0] act_v;
    wr[0]   = 1'b1;
    data[0] = 9'h04B;
    tick();
    wr[0] = 1'b0;
    // land in the middle of data bit 3 (line slot 4)
    repeat (4 * DIV + 4) tick();
    compared++;
    if (tx[0] !== model_line(0, 9'h04B, 4)) begin
      mismatched++;
      $display("FAIL rst_mid pre-reset tx: got %b want %b", tx[0], model_line(0, 9'h04B, 4));
    end
    #1;
    rst = 1'b1;
    #1;  // still well before the next rising edge
    act_v = {tx[0], done[0], ready[0]};
    compared++;
    if (act_v !== 3'b101) begin
      mismatched++;
      $display("FAIL rst_mid async {tx,done,ready}: got %b want 101", act_v);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    frame_q = '{9'h04B};
    send_frames(0, 0, "after_rst_4B");
  endtask

  task automatic test_random();
    int i;
    int nf;
    int mode;
    for (int r = 0; r < 16; r++) begin
      i    = r % N_INST;
      nf   = $urandom_range(1, 3);
      mode = $urandom_range(0, 1);
      frame_q.delete();
      for (int k = 0; k < nf; k++)
        frame_q.push_back(9'($urandom) & 9'((1 << CFG_DB[i]) - 1));
      send_frames(i, mode, $sformatf("rand%0d", r));
    end
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    for (int i = 0; i < N_INST; i++) begin
      wr[i]   = 1'b0;
      data[i] = '0;
    end
    test_reset();
    test_single_frame();
    test_parity_stop2();
    test_back_to_back();
    test_ignored_write();
    test_reset_mid_frame();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
